intersection_cmd_driver: RTL and testbench



---
 rtl/intersection_cmd_driver_pkg.sv | 39 +++
 rtl/intersection_cmd_driver_fifo.sv | 63 ++++++
 rtl/intersection_cmd_driver.sv | 165 ++++++++++++++++
 tb/tb_intersection_cmd_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_cmd_driver_pkg.sv
// Shared encodings for the intersection simulator command driver.
package intersection_cmd_driver_pkg;

  // Road command opcodes: bit 1 = add, bit 0 = road B
  localparam logic [1:0] OP_REM_A = 2'b00;
  localparam logic [1:0] OP_REM_B = 2'b01;
  localparam logic [1:0] OP_ADD_A = 2'b10;
  localparam logic [1:0] OP_ADD_B = 2'b11;

  // Simulator mode values driven on `mode`
  localparam logic [2:0] MODE_IDLE    = 3'b000;
  localparam logic [2:0] MODE_DISPLAY = 3'b100;

  // Road capacity, matching the simulator queue depth
  localparam int MAX_CARS_DEFAULT = 30;

  // Saturation ceiling of the 5-bit violation counter
  localparam logic [4:0] VIOL_MAX = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DISPLAY
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] plate;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic op_is_add(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/intersection_cmd_driver_fifo.sv
// Synchronous command queue; a push is refused when full even if a pop
// happens in the same cycle.
module cmd_fifo
  import intersection_cmd_driver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/intersection_cmd_driver.sv
// Command transmitter for the intersection simulator: queues road commands,
// validates them against shadow occupancy and serialises each one into a
// setup/pulse/hold strobe on mode/plateIn/action.
module intersection_cmd_driver
  import intersection_cmd_driver_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int MAX_CARS     = MAX_CARS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_plate,
  input  logic       display_req,
  input  logic       greenForA,
  input  logic       greenForB,
  output logic [2:0] mode,
  output logic [4:0] plateIn,
  output logic       action,
  output logic       busy,
  output logic       drop_pulse,
  output logic [4:0] violations,
  output logic [4:0] carsA,
  output logic [4:0] carsB
);

  localparam logic [4:0] CAP        = 5'(MAX_CARS);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

  state_t           state;
  logic [7:0]       phase;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [CMD_W-1:0] head_bits;
  cmd_t             head;
  logic             head_legal;

  assign cmd_ready = !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign head      = cmd_t'(head_bits);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && !fifo_full),
    .pop   (pop),
    .din   ({cmd_op, cmd_plate}),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Reject commands that would underflow or overflow a road's shadow count
  always_comb begin
    head_legal = 1'b1;
    case (head.op)
      OP_REM_A: head_legal = (carsA != '0);
      OP_REM_B: head_legal = (carsB != '0);
      OP_ADD_A: head_legal = (carsA != CAP);
      OP_ADD_B: head_legal = (carsB != CAP);
      default:  head_legal = 1'b0;
    endcase
  end

  // Strobe sequencer; shadow counts and violations update on PULSE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= '0;
      mode       <= MODE_IDLE;
      plateIn    <= '0;
      action     <= 1'b0;
      drop_pulse <= 1'b0;
      carsA      <= '0;
      carsB      <= '0;
      violations <= '0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_legal) begin
              mode    <= {1'b0, head.op};
              plateIn <= op_is_add(head.op) ? head.plate : '0;
              phase   <= '0;
              state   <= ST_SETUP;
            end else begin
              drop_pulse <= 1'b1;
            end
          end else if (display_req) begin
            mode  <= MODE_DISPLAY;
            state <= ST_DISPLAY;
          end
        end
        ST_SETUP: begin
          if (phase == SETUP_LAST) begin
            phase  <= '0;
            action <= 1'b1;
            state  <= ST_PULSE;
            // mode[1:0] still holds the in-flight opcode
            case (mode[1:0])
              OP_ADD_A: carsA <= carsA + 5'd1;
              OP_ADD_B: carsB <= carsB + 5'd1;
              OP_REM_A: begin
                carsA <= carsA - 5'd1;
                if (!greenForA && (violations != VIOL_MAX)) begin
                  violations <= violations + 5'd1;
                end
              end
              default: begin
                carsB <= carsB - 5'd1;
                if (!greenForB && (violations != VIOL_MAX)) begin
                  violations <= violations + 5'd1;
                end
              end
            endcase
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_PULSE: begin
          if (phase == PULSE_LAST) begin
            phase  <= '0;
            action <= 1'b0;
            state  <= ST_HOLD;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_HOLD: begin
          if (phase == HOLD_LAST) begin
            phase   <= '0;
            mode    <= MODE_IDLE;
            plateIn <= '0;
            state   <= ST_IDLE;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_DISPLAY: begin
          if (!display_req) begin
            mode  <= MODE_IDLE;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_cmd_driver.sv
// Directed bench for intersection_cmd_driver at default parameters.
module tb_intersection_cmd_driver;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_plate;
  logic       display_req;
  logic       greenForA;
  logic       greenForB;
  logic [2:0] mode;
  logic [4:0] plateIn;
  logic       action;
  logic       busy;
  logic       drop_pulse;
  logic [4:0] violations;
  logic [4:0] carsA;
  logic [4:0] carsB;

  int checks = 0;
  int errors = 0;

  intersection_cmd_driver #(
    .FIFO_DEPTH   (4),
    .SETUP_CYCLES (1),
    .PULSE_CYCLES (1),
    .HOLD_CYCLES  (1),
    .MAX_CARS     (30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_plate   (cmd_plate),
    .display_req (display_req),
    .greenForA   (greenForA),
    .greenForB   (greenForB),
    .mode        (mode),
    .plateIn     (plateIn),
    .action      (action),
    .busy        (busy),
    .drop_pulse  (drop_pulse),
    .violations  (violations),
    .carsA       (carsA),
    .carsB       (carsB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [4:0] plate);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_plate = plate;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Step until action rises, then check the in-flight command and the wait
  task automatic wait_action(input string tag, input logic [2:0] exp_mode,
                             input logic [4:0] exp_plate, input int exp_n);
    int n = 0;
    do begin
      step();
      n++;
    end while (!action && n < 12);
    chk({tag, "_action"}, 32'(action), 32'd1);
    chk({tag, "_mode"}, 32'(mode), 32'(exp_mode));
    chk({tag, "_plate"}, 32'(plateIn), 32'(exp_plate));
    chk({tag, "_gap"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_plate   = 5'd0;
    display_req = 1'b0;
    greenForA   = 1'b1;
    greenForB   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_action", 32'(action), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_plate", 32'(plateIn), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cars", 32'({carsA, carsB}), 32'd0);
    chk("rst_viol", 32'(violations), 32'd0);
    rst = 1'b0;
    step();

    // First command latency: addA plate 17 accepted at edge t
    push(2'b10, 5'd17);
    chk("t0_mode", 32'(mode), 32'd0);
    chk("t0_busy", 32'(busy), 32'd1);
    step();
    chk("t1_mode", 32'(mode), 32'b010);
    chk("t1_plate", 32'(plateIn), 32'd17);
    chk("t1_action", 32'(action), 32'd0);
    step();
    chk("t2_action", 32'(action), 32'd1);
    chk("t2_carsA", 32'(carsA), 32'd1);
    step();
    chk("t3_action", 32'(action), 32'd0);
    chk("t3_mode", 32'(mode), 32'b010);
    chk("t3_plate", 32'(plateIn), 32'd17);
    step();
    chk("t4_mode", 32'(mode), 32'd0);
    chk("t4_plate", 32'(plateIn), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // Green remove empties road A without a violation
    push(2'b00, 5'd3);
    wait_idle("remA_idle", 10);
    chk("remA_carsA", 32'(carsA), 32'd0);
    chk("remA_viol", 32'(violations), 32'd0);

    // Remove from an empty road is discarded
    push(2'b00, 5'd0);
    step();
    chk("drop_pulse_hi", 32'(drop_pulse), 32'd1);
    chk("drop_action", 32'(action), 32'd0);
    chk("drop_mode", 32'(mode), 32'd0);
    step();
    chk("drop_pulse_lo", 32'(drop_pulse), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_carsA", 32'(carsA), 32'd0);
    chk("drop_viol", 32'(violations), 32'd0);

    // Fill road B to capacity, then overflow attempt
    for (int i = 0; i < 30; i++) begin
      push(2'b11, 5'(i));
      wait_idle("fillB_idle", 10);
    end
    chk("fillB_carsB", 32'(carsB), 32'd30);
    push(2'b11, 5'd31);
    step();
    chk("fullB_drop", 32'(drop_pulse), 32'd1);
    chk("fullB_action", 32'(action), 32'd0);
    wait_idle("fullB_idle", 10);
    chk("fullB_carsB", 32'(carsB), 32'd30);

    // Red-light removals on road A, saturating at 31
    greenForA = 1'b0;
    push(2'b10, 5'd1);
    wait_idle("red1_add", 10);
    push(2'b00, 5'd0);
    wait_idle("red1_rem", 10);
    chk("red1_viol", 32'(violations), 32'd1);
    for (int i = 0; i < 35; i++) begin
      push(2'b10, 5'd2);
      wait_idle("redN_add", 10);
      push(2'b00, 5'd0);
      wait_idle("redN_rem", 10);
      if (i == 28) chk("red30_viol", 32'(violations), 32'd30);
    end
    chk("sat_viol", 32'(violations), 32'd31);
    chk("sat_carsA", 32'(carsA), 32'd0);
    greenForA = 1'b1;

    // Five back-to-back commands: queue fills, issue order and spacing kept
    push(2'b10, 5'd1);
    push(2'b10, 5'd2);
    push(2'b01, 5'd9);
    chk("b2b_c0_action", 32'(action), 32'd1);
    chk("b2b_c0_mode", 32'(mode), 32'b010);
    chk("b2b_c0_plate", 32'(plateIn), 32'd1);
    push(2'b10, 5'd3);
    chk("b2b_ready_e3", 32'(cmd_ready), 32'd1);
    push(2'b00, 5'd4);
    chk("b2b_ready_full", 32'(cmd_ready), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_action("b2b_c1", 3'b010, 5'd2, 2);
    wait_action("b2b_c2", 3'b001, 5'd0, 4);
    wait_action("b2b_c3", 3'b010, 5'd3, 4);
    wait_action("b2b_c4", 3'b000, 5'd0, 4);
    wait_idle("b2b_idle", 10);
    chk("b2b_carsA", 32'(carsA), 32'd2);
    chk("b2b_carsB", 32'(carsB), 32'd29);
    chk("b2b_viol", 32'(violations), 32'd31);

    // Display mode parks the simulator while commands queue
    display_req = 1'b1;
    step();
    chk("disp_mode", 32'(mode), 32'b100);
    push(2'b10, 5'd7);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("disp_hold_action", 32'(action), 32'd0);
      chk("disp_hold_mode", 32'(mode), 32'b100);
    end
    chk("disp_busy", 32'(busy), 32'd1);
    display_req = 1'b0;
    step();
    chk("disp_exit_mode", 32'(mode), 32'd0);
    step();
    chk("disp_cmd_mode", 32'(mode), 32'b010);
    chk("disp_cmd_plate", 32'(plateIn), 32'd7);
    step();
    chk("disp_cmd_action", 32'(action), 32'd1);
    chk("disp_cmd_carsA", 32'(carsA), 32'd3);
    wait_idle("disp_idle", 10);

    // Asynchronous reset in the middle of a pulse
    push(2'b11, 5'd12);
    wait_action("mid", 3'b011, 5'd12, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_action", 32'(action), 32'd0);
    chk("mid_rst_mode", 32'(mode), 32'd0);
    chk("mid_rst_plate", 32'(plateIn), 32'd0);
    chk("mid_rst_cars", 32'({carsA, carsB}), 32'd0);
    chk("mid_rst_viol", 32'(violations), 32'd0);
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_action", 32'(action), 32'd0);
    chk("post_rst_mode", 32'(mode), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
